// File: rtl/exe_w12_pkg.sv
// -----------------------------------------------------------------------------
// exe_w12_pkg
// Shared definitions for the 12-series execution unit issue path.
//   state_t      : issue sequencer states (IDLE, EXEC, RESP)
//   OP_*         : operation codes understood by the execution unit
//   ST_*         : bit positions inside the execution unit status word
// The sequencer only interprets ST_ERR. Every other code and bit is passed
// through untouched.
// -----------------------------------------------------------------------------
package exe_w12_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   // Operation codes
   localparam logic [1:0] OP_ADD  = 2'd0;
   localparam logic [1:0] OP_GEQ  = 2'd1;
   localparam logic [1:0] OP_ABS  = 2'd2;
   localparam logic [1:0] OP_BSET = 2'd3;

   // Status bit indices
   localparam int ST_ERR  = 0;
   localparam int ST_ZERO = 1;
   localparam int ST_NEG  = 2;
   localparam int ST_POP  = 3;

endpackage : exe_w12_pkg

// File: rtl/exe_issue_w12_sat_cnt.sv
// -----------------------------------------------------------------------------
// sat_cnt
// Saturating up-counter with a synchronous clear.
// Ports:
//   clk   : clock, rising edge
//   rsn   : asynchronous active-low reset
//   clr   : synchronous clear. It takes priority over inc.
//   inc   : count one event this cycle
//   count : current value. It holds at 2^C-1 instead of wrapping.
// -----------------------------------------------------------------------------
module sat_cnt #(
   parameter int C = 8
) (
   input  logic         clk,
   input  logic         rsn,
   input  logic         clr,
   input  logic         inc,
   output logic [C-1:0] count
);

   logic at_max;

   assign at_max = (count == {C{1'b1}});

   always_ff @(posedge clk or negedge rsn) begin
      if (!rsn) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && !at_max) begin
         count <= count + 1'b1;
      end
   end

endmodule : sat_cnt

// File: rtl/exe_issue_w12.sv
// -----------------------------------------------------------------------------
// exe_issue_w12
// Sequencer for the 12-series execution unit interface.
// The module accepts one request, drives it to the execution unit, and captures
// the combinational answer one cycle later. It then returns that answer on a
// response channel. It also counts completed operations and erroring operations.
//
// Handshake rule (both channels): a transfer happens on a rising clock edge
// where valid and ready are both high. The sender keeps valid and its data
// stable until that edge. The receiver may raise or lower ready at any time.
//
// Ports:
//   i_clk, i_rsn                 : clock and asynchronous active-low reset
//   i_req_valid / o_req_ready    : request handshake. Ready is high only in IDLE.
//   i_req_oper/argA/argB         : request payload
//   o_exe_oper/argA/argB         : registered drive to the execution unit
//   i_exe_result/status          : combinational answer from the execution unit
//   o_rsp_valid / i_rsp_ready    : response handshake
//   o_rsp_result/status          : captured answer. It is held while in RESP.
//   i_clr_cnt                    : synchronous clear of both counters
//   o_op_cnt, o_err_cnt          : saturating counters
//   o_state                      : current sequencer state, for observation
// -----------------------------------------------------------------------------
module exe_issue_w12
   import exe_w12_pkg::*;
#(
   parameter int M = 4,
   parameter int N = 2,
   parameter int C = 8
) (
   input  logic         i_clk,
   input  logic         i_rsn,
   input  logic         i_req_valid,
   output logic         o_req_ready,
   input  logic [N-1:0] i_req_oper,
   input  logic [M-1:0] i_req_argA,
   input  logic [M-1:0] i_req_argB,
   output logic [N-1:0] o_exe_oper,
   output logic [M-1:0] o_exe_argA,
   output logic [M-1:0] o_exe_argB,
   input  logic [M-1:0] i_exe_result,
   input  logic [M-1:0] i_exe_status,
   output logic         o_rsp_valid,
   input  logic         i_rsp_ready,
   output logic [M-1:0] o_rsp_result,
   output logic [M-1:0] o_rsp_status,
   input  logic         i_clr_cnt,
   output logic [C-1:0] o_op_cnt,
   output logic [C-1:0] o_err_cnt,
   output state_t       o_state
);

   state_t state;
   state_t state_n;
   logic   idle_ready;
   logic   accept;
   logic   capture;
   logic   rsp_hs;
   logic   err_inc;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge i_clk or negedge i_rsn) begin
      if (!i_rsn) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n    = state;
      idle_ready = 1'b0;
      accept     = 1'b0;
      capture    = 1'b0;
      rsp_hs     = 1'b0;
      case (state)
         IDLE: begin
            idle_ready = 1'b1;
            if (i_req_valid) begin
               accept  = 1'b1;
               state_n = EXEC;
            end
         end
         EXEC: begin
            // The execution unit has had one full cycle to settle on o_exe_*.
            capture = 1'b1;
            state_n = RESP;
         end
         RESP: begin
            if (i_rsp_ready) begin
               rsp_hs  = 1'b1;
               state_n = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // The reset term keeps ready low while reset is asserted, even though the
   // state is already IDLE at that point.
   assign o_req_ready = idle_ready & i_rsn;
   assign o_rsp_valid = (state == RESP);
   assign o_state     = state;

   // ------------------------------------------------------- issue registers
   // These registers load only on acceptance. Between operations they keep
   // the last issued values.
   always_ff @(posedge i_clk or negedge i_rsn) begin
      if (!i_rsn) begin
         o_exe_oper <= '0;
         o_exe_argA <= '0;
         o_exe_argB <= '0;
      end else if (accept) begin
         o_exe_oper <= i_req_oper;
         o_exe_argA <= i_req_argA;
         o_exe_argB <= i_req_argB;
      end
   end

   // ---------------------------------------------------- response registers
   // These registers load only when leaving EXEC. In RESP they ignore the
   // execution unit entirely.
   always_ff @(posedge i_clk or negedge i_rsn) begin
      if (!i_rsn) begin
         o_rsp_result <= '0;
         o_rsp_status <= '0;
      end else if (capture) begin
         o_rsp_result <= i_exe_result;
         o_rsp_status <= i_exe_status;
      end
   end

   // -------------------------------------------------------------- counters
   assign err_inc = rsp_hs & o_rsp_status[ST_ERR];

   sat_cnt #(.C(C)) u_op_cnt (
      .clk   (i_clk),
      .rsn   (i_rsn),
      .clr   (i_clr_cnt),
      .inc   (rsp_hs),
      .count (o_op_cnt)
   );

   sat_cnt #(.C(C)) u_err_cnt (
      .clk   (i_clk),
      .rsn   (i_rsn),
      .clr   (i_clr_cnt),
      .inc   (err_inc),
      .count (o_err_cnt)
   );

endmodule : exe_issue_w12

// File: tb/tb_exe_issue_w12.sv
// -----------------------------------------------------------------------------
// tb_exe_issue_w12
// Directed bench for exe_issue_w12 (M=4, N=2, C=2). A small combinational
// model of the execution unit sits downstream. Expected responses are
// hand-computed constants pushed into exp_q at issue time. A monitor pops and
// compares them on every response handshake.
// -----------------------------------------------------------------------------
module tb_exe_issue_w12;
   import exe_w12_pkg::*;

   localparam int M = 4;
   localparam int N = 2;
   localparam int C = 2;

   logic         clk;
   logic         rst_n;
   logic         req_valid;
   logic         req_ready;
   logic [N-1:0] req_oper;
   logic [M-1:0] req_arg_a;
   logic [M-1:0] req_arg_b;
   logic [N-1:0] exe_oper;
   logic [M-1:0] exe_arg_a;
   logic [M-1:0] exe_arg_b;
   logic [M-1:0] exe_result;
   logic [M-1:0] exe_status;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [M-1:0] rsp_result;
   logic [M-1:0] rsp_status;
   logic         clr_cnt;
   logic [C-1:0] op_cnt;
   logic [C-1:0] err_cnt;
   state_t       dut_state;
   logic         exe_glitch;

   int compared   = 0;
   int mismatched = 0;
   logic [2*M-1:0] exp_q[$];

   exe_issue_w12 #(.M(M), .N(N), .C(C)) dut (
      .i_clk        (clk),
      .i_rsn        (rst_n),
      .i_req_valid  (req_valid),
      .o_req_ready  (req_ready),
      .i_req_oper   (req_oper),
      .i_req_argA   (req_arg_a),
      .i_req_argB   (req_arg_b),
      .o_exe_oper   (exe_oper),
      .o_exe_argA   (exe_arg_a),
      .o_exe_argB   (exe_arg_b),
      .i_exe_result (exe_result),
      .i_exe_status (exe_status),
      .o_rsp_valid  (rsp_valid),
      .i_rsp_ready  (rsp_ready),
      .o_rsp_result (rsp_result),
      .o_rsp_status (rsp_status),
      .i_clr_cnt    (clr_cnt),
      .o_op_cnt     (op_cnt),
      .o_err_cnt    (err_cnt),
      .o_state      (dut_state)
   );

   // ------------------------------------------------ clock / reset / watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------- execution unit model
   // ADD  : A+B, carry-out flags ERR
   // GEQ  : 1 when A >= B (unsigned)
   // ABS  : two's complement to sign-magnitude, NEG when negative, ERR on -8
   // BSET : A with bit B set, ERR when B is out of range (result 0)
   // ZERO : set whenever the result is 0
   // exe_glitch corrupts the outputs so the bench can show the response is held.
   always_comb begin
      logic [M:0]   sum;
      logic [M-1:0] neg;
      logic [M-1:0] r;
      logic [M-1:0] s;
      sum = {1'b0, exe_arg_a} + {1'b0, exe_arg_b};
      neg = -exe_arg_a;
      r   = '0;
      s   = '0;
      case (exe_oper)
         OP_ADD: begin
            r         = sum[M-1:0];
            s[ST_ERR] = sum[M];
         end
         OP_GEQ: begin
            r = (exe_arg_a >= exe_arg_b) ? 4'd1 : 4'd0;
         end
         OP_ABS: begin
            if (exe_arg_a[M-1]) begin
               s[ST_NEG] = 1'b1;
               if (exe_arg_a == 4'b1000) s[ST_ERR] = 1'b1;
               else r = {1'b1, neg[M-2:0]};
            end else begin
               r = exe_arg_a;
            end
         end
         default: begin
            if (exe_arg_b >= 4'd4) s[ST_ERR] = 1'b1;
            else r = exe_arg_a | (4'b0001 << exe_arg_b);
         end
      endcase
      s[ST_ZERO] = (r == '0);
      exe_result = exe_glitch ? ~r : r;
      exe_status = exe_glitch ? ~s : s;
   end

   // ----------------------------------------------------------------- checks
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: on each response handshake, compare against exp_q.
   always @(negedge clk) begin
      if (rst_n && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_rsp", {24'd0, rsp_result, rsp_status}, 32'hFFFF_FFFF);
         end else begin
            check("rsp_data", {24'd0, rsp_result, rsp_status}, {24'd0, exp_q.pop_front()});
         end
      end
   end

   // ---------------------------------------------------------------- drivers
   // Issues a request and waits for acceptance. It returns 1 ns after the
   // accepting edge, when the DUT is in EXEC.
   task automatic issue(input logic [N-1:0] op, input logic [M-1:0] a, input logic [M-1:0] b,
                        input logic [M-1:0] er, input logic [M-1:0] es, input bit push);
      int n = 0;
      if (push) exp_q.push_back({er, es});
      req_valid = 1'b1;
      req_oper  = op;
      req_arg_a = a;
      req_arg_b = b;
      while (!req_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 20) check("accept_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("exe_oper", {30'd0, exe_oper}, {30'd0, op});
      check("exe_arg_a", {28'd0, exe_arg_a}, {28'd0, a});
      check("exe_arg_b", {28'd0, exe_arg_b}, {28'd0, b});
      check("rsp_valid_k1", {31'd0, rsp_valid}, 32'd0);
   endtask

   // Completes the response with rsp_ready high. It can also pulse clr_cnt
   // on the handshake edge.
   task automatic finish_rsp(input bit clr_on_hs);
      @(posedge clk); #1;
      check("rsp_valid_k2", {31'd0, rsp_valid}, 32'd1);
      if (clr_on_hs) clr_cnt = 1'b1;
      @(posedge clk); #1;
      clr_cnt = 1'b0;
      check("rsp_valid_after_hs", {31'd0, rsp_valid}, 32'd0);
      check("req_ready_after_hs", {31'd0, req_ready}, 32'd1);
   endtask

   task automatic check_cnt(input string name, input logic [C-1:0] op_e, input logic [C-1:0] err_e);
      check({name, "_op_cnt"}, {30'd0, op_cnt}, {30'd0, op_e});
      check({name, "_err_cnt"}, {30'd0, err_cnt}, {30'd0, err_e});
   endtask

   // --------------------------------------------------------------- stimulus
   initial begin
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_oper   = '0;
      req_arg_a  = '0;
      req_arg_b  = '0;
      rsp_ready  = 1'b1;
      clr_cnt    = 1'b0;
      exe_glitch = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_req_ready", {31'd0, req_ready}, 32'd0);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_exe_oper", {30'd0, exe_oper}, 32'd0);
      check_cnt("rst", 2'd0, 2'd0);
      rst_n = 1'b1;
      #1;
      check("idle_req_ready", {31'd0, req_ready}, 32'd1);
      check("idle_state", {30'd0, dut_state}, {30'd0, IDLE});

      // Add: 3+5
      issue(OP_ADD, 4'd3, 4'd5, 4'b1000, 4'b0000, 1'b1);
      check("exec_req_ready", {31'd0, req_ready}, 32'd0);
      finish_rsp(1'b0);
      check_cnt("add", 2'd1, 2'd0);

      // Bit-set with out-of-range index
      issue(OP_BSET, 4'b0001, 4'd7, 4'b0000, 4'b0011, 1'b1);
      finish_rsp(1'b0);
      check_cnt("bset", 2'd2, 2'd1);

      // Sign conversion of -5
      issue(OP_ABS, 4'b1011, 4'd0, 4'b1101, 4'b0100, 1'b1);
      finish_rsp(1'b0);
      check_cnt("abs", 2'd3, 2'd1);

      // Clear without a handshake
      clr_cnt = 1'b1;
      @(posedge clk); #1;
      clr_cnt = 1'b0;
      check_cnt("clr", 2'd0, 2'd0);

      // Back-pressure: GEQ 5,3 held for 5 cycles while the execution unit
      // outputs are corrupted and a new request waits.
      rsp_ready = 1'b0;
      issue(OP_GEQ, 4'd5, 4'd3, 4'b0001, 4'b0000, 1'b1);
      @(posedge clk); #1;
      check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      exe_glitch = 1'b1;
      exp_q.push_back({4'b0010, 4'b0000});
      req_valid = 1'b1;
      req_oper  = OP_ADD;
      req_arg_a = 4'd1;
      req_arg_b = 4'd1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
         check("bp_hold_result", {28'd0, rsp_result}, 32'd1);
         check("bp_hold_status", {28'd0, rsp_status}, 32'd0);
         check("bp_req_ready", {31'd0, req_ready}, 32'd0);
         check("bp_exe_oper", {30'd0, exe_oper}, {30'd0, OP_GEQ});
         check("bp_exe_args", {24'd0, exe_arg_a, exe_arg_b}, 32'h53);
         check_cnt("bp_hold", 2'd0, 2'd0);
      end
      exe_glitch = 1'b0;
      rsp_ready  = 1'b1;
      @(posedge clk); #1;
      check_cnt("bp_hs", 2'd1, 2'd0);
      issue(OP_ADD, 4'd1, 4'd1, 4'b0010, 4'b0000, 1'b0);
      finish_rsp(1'b0);
      check_cnt("bp_next", 2'd2, 2'd0);

      // Reset in EXEC: the op is dropped and every output goes to 0.
      issue(OP_BSET, 4'd0, 4'd1, 4'b0010, 4'b0000, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_req_ready", {31'd0, req_ready}, 32'd0);
      check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("mid_rst_rsp_data", {24'd0, rsp_result, rsp_status}, 32'd0);
      check("mid_rst_exe", {24'd0, exe_oper, exe_arg_a, exe_arg_b}, 32'd0);
      check_cnt("mid_rst", 2'd0, 2'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      check("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check("post_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
      end

      // Saturation at 3 with C=2, then a clear coinciding with a handshake.
      issue(OP_ADD, 4'd3, 4'd5, 4'b1000, 4'b0000, 1'b1);
      finish_rsp(1'b0);
      check_cnt("sat1", 2'd1, 2'd0);
      issue(OP_BSET, 4'b0001, 4'd7, 4'b0000, 4'b0011, 1'b1);
      finish_rsp(1'b0);
      check_cnt("sat2", 2'd2, 2'd1);
      issue(OP_ABS, 4'b1011, 4'd0, 4'b1101, 4'b0100, 1'b1);
      finish_rsp(1'b0);
      check_cnt("sat3", 2'd3, 2'd1);
      issue(OP_ADD, 4'd15, 4'd1, 4'b0000, 4'b0011, 1'b1);
      finish_rsp(1'b0);
      check_cnt("sat4", 2'd3, 2'd2);
      issue(OP_GEQ, 4'd5, 4'd3, 4'b0001, 4'b0000, 1'b1);
      finish_rsp(1'b1);
      check_cnt("clr_hs", 2'd0, 2'd0);

      repeat (3) @(posedge clk);
      #1;
      check("exp_q_empty", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule : tb_exe_issue_w12
